countdown_ctrl: RTL and testbench



---
 rtl/countdown_ctrl_pkg.sv | 19 +
 rtl/countdown_ctrl_tick_gen.sv | 29 ++
 rtl/countdown_ctrl.sv | 157 +++++++++++++++
 tb/tb_countdown_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_ctrl_pkg.sv
// Shared types and constants for the countdown timer controller.
package countdown_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam int unsigned      FIELD_W   = 6;
  localparam logic [FIELD_W-1:0] MAX_FIELD = 6'd59;

  // Limit a preset minutes/seconds field to the displayable range.
  function automatic logic [FIELD_W-1:0] clamp_field(input logic [FIELD_W-1:0] v);
    return (v > MAX_FIELD) ? MAX_FIELD : v;
  endfunction

endpackage

// File: rtl/countdown_ctrl_tick_gen.sv
// Prescaler producing a single-cycle tick enable every DIV clocks.
// The count is held while en is low, so a paused partial second survives.
module tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // Prescaler count: clear has priority over advancing; wraps after LAST.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Minutes/seconds countdown controller: load, run, pause/resume, alarm at zero.
// All outputs are registered; tick is the prescaler pulse delayed to line up
// with the count update it caused.
module countdown_ctrl #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned TICK_HZ     = 1,
  parameter int unsigned ALARM_TICKS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       running,
  output logic       paused,
  output logic       alarm,
  output logic       tick
);

  import countdown_ctrl_pkg::*;

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned AW  = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS - 1);

  state_t               state, state_nxt;
  logic [FIELD_W-1:0]   min_nxt, sec_nxt;
  logic [FIELD_W-1:0]   dec_min, dec_sec;
  logic [AW-1:0]        acnt, acnt_nxt;
  logic                 tick_int;
  logic                 pre_en;
  logic                 pre_clr;
  logic                 is_zero;

  assign pre_en  = (state == RUN) || (state == ALARM);
  assign is_zero = (min == '0) && (sec == '0);

  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick_int)
  );

  // One-second decrement with minute borrow; never goes below 00:00.
  always_comb begin
    dec_min = min;
    dec_sec = sec;
    if (sec != '0) begin
      dec_sec = sec - 6'd1;
    end else if (min != '0) begin
      dec_min = min - 6'd1;
      dec_sec = MAX_FIELD;
    end
  end

  // Next-state and count logic; command priority is clear > pause > start > load.
  always_comb begin
    state_nxt = state;
    min_nxt   = min;
    sec_nxt   = sec;
    acnt_nxt  = acnt;
    pre_clr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (clear) begin
          min_nxt = '0;
          sec_nxt = '0;
        end else if (start && !is_zero) begin
          state_nxt = RUN;
          pre_clr   = 1'b1;
        end else if (load) begin
          min_nxt = clamp_field(set_min);
          sec_nxt = clamp_field(set_sec);
        end
      end
      RUN: begin
        if (clear) begin
          state_nxt = IDLE;
          min_nxt   = '0;
          sec_nxt   = '0;
        end else begin
          // A coinciding tick is applied before pause takes effect; reaching
          // zero sends the timer to ALARM even if pause arrives on that edge.
          if (tick_int) begin
            min_nxt = dec_min;
            sec_nxt = dec_sec;
          end
          if (tick_int && (dec_min == '0) && (dec_sec == '0)) begin
            state_nxt = ALARM;
            acnt_nxt  = '0;
            pre_clr   = 1'b1;
          end else if (pause) begin
            state_nxt = PAUSE;
          end
        end
      end
      PAUSE: begin
        if (clear) begin
          state_nxt = IDLE;
          min_nxt   = '0;
          sec_nxt   = '0;
        end else if (!pause && start) begin
          state_nxt = RUN;
        end
      end
      ALARM: begin
        if (clear || start) begin
          state_nxt = IDLE;
          acnt_nxt  = '0;
          min_nxt   = '0;
          sec_nxt   = '0;
        end else if (tick_int) begin
          if (acnt == ALARM_LAST) begin
            state_nxt = IDLE;
            acnt_nxt  = '0;
          end else begin
            acnt_nxt = acnt + AW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, count and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      min     <= '0;
      sec     <= '0;
      acnt    <= '0;
      running <= 1'b0;
      paused  <= 1'b0;
      alarm   <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state   <= state_nxt;
      min     <= min_nxt;
      sec     <= sec_nxt;
      acnt    <= acnt_nxt;
      running <= (state_nxt == RUN);
      paused  <= (state_nxt == PAUSE);
      alarm   <= (state_nxt == ALARM);
      tick    <= tick_int;
    end
  end

endmodule

// File: tb/tb_countdown_ctrl.sv
// Scoreboard bench for countdown_ctrl (CLK_HZ=10, TICK_HZ=1, ALARM_TICKS=3).
module tb_countdown_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
  logic [5:0] set_min = '0, set_sec = '0;
  logic [5:0] min, sec;
  logic       running, paused, alarm, tick;

  countdown_ctrl #(
    .CLK_HZ(10),
    .TICK_HZ(1),
    .ALARM_TICKS(3)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .start(start), .pause(pause),
    .clear(clear), .set_min(set_min), .set_sec(set_sec), .min(min), .sec(sec),
    .running(running), .paused(paused), .alarm(alarm), .tick(tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [5:0] m, s;
    logic       run, pau, alm, tck;
    string      name;
  } at_t;

  typedef struct {
    int         cyc;
    logic [5:0] m, s;
    logic       alm;
    string      name;
  } tk_t;

  at_t at_q[$];
  tk_t tk_q[$];
  int  errors = 0;
  int  checks = 0;

  function automatic void exp_at(input int c, input logic [5:0] m, s,
                                 input logic run, pau, alm, tck, input string n);
    at_t e;
    e.cyc = c; e.m = m; e.s = s; e.run = run; e.pau = pau; e.alm = alm; e.tck = tck; e.name = n;
    at_q.push_back(e);
  endfunction

  function automatic void exp_tick(input int c, input logic [5:0] m, s,
                                   input logic alm, input string n);
    tk_t e;
    e.cyc = c; e.m = m; e.s = s; e.alm = alm; e.name = n;
    tk_q.push_back(e);
  endfunction

  // Monitor: cycle-tagged state checks plus one check per observed tick.
  initial begin
    forever begin
      @(negedge clk);
      while (at_q.size() > 0 && at_q[0].cyc <= cyc) begin
        at_t e;
        e = at_q.pop_front();
        checks++;
        if (e.cyc != cyc || min !== e.m || sec !== e.s || running !== e.run ||
            paused !== e.pau || alarm !== e.alm || tick !== e.tck) begin
          errors++;
          $display("FAIL %s @cyc %0d: got %0d:%0d run=%b pau=%b alm=%b tick=%b, want %0d:%0d run=%b pau=%b alm=%b tick=%b (cyc %0d)",
                   e.name, cyc, min, sec, running, paused, alarm, tick,
                   e.m, e.s, e.run, e.pau, e.alm, e.tck, e.cyc);
        end
      end
      if (tick === 1'b1) begin
        checks++;
        if (tk_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tick @cyc %0d: got %0d:%0d alm=%b, want no tick", cyc, min, sec, alarm);
        end else begin
          tk_t t;
          t = tk_q.pop_front();
          if (t.cyc != cyc || min !== t.m || sec !== t.s || alarm !== t.alm) begin
            errors++;
            $display("FAIL %s: got tick @cyc %0d %0d:%0d alm=%b, want @cyc %0d %0d:%0d alm=%b",
                     t.name, cyc, min, sec, alarm, t.cyc, t.m, t.s, t.alm);
          end
        end
      end
    end
  end

  // Drive a one-cycle command from a negedge; it is sampled at edge cyc+1.
  task automatic cmd(input logic l, st, p, c, input logic [5:0] m, s);
    load = l; start = st; pause = p; clear = c; set_min = m; set_sec = s;
    @(negedge clk);
    load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int S;
    @(negedge clk);
    // Reset state
    exp_at(3, 0, 0, 0, 0, 0, 0, "reset_state");
    wait_until(4);
    reset = 1'b0;

    // 00:03 countdown into alarm, then auto-return to IDLE
    S = cyc + 1;
    exp_at(S, 0, 3, 0, 0, 0, 0, "load_0003");
    cmd(1, 0, 0, 0, 6'd0, 6'd3);
    S = cyc + 1;
    exp_at(S, 0, 3, 1, 0, 0, 0, "start_run");
    exp_tick(S + 10, 0, 2, 0, "t_sec2");
    exp_tick(S + 20, 0, 1, 0, "t_sec1");
    exp_tick(S + 30, 0, 0, 1, "t_sec0_alarm");
    exp_at(S + 30, 0, 0, 0, 0, 1, 1, "alarm_on");
    exp_tick(S + 40, 0, 0, 1, "alarm_t1");
    exp_tick(S + 50, 0, 0, 1, "alarm_t2");
    exp_tick(S + 60, 0, 0, 0, "alarm_t3");
    exp_at(S + 61, 0, 0, 0, 0, 0, 0, "alarm_off_idle");
    cmd(0, 1, 0, 0, 6'd0, 6'd0);
    wait_until(S + 62);

    // 01:00 borrow to 00:59
    S = cyc + 1;
    exp_at(S, 1, 0, 0, 0, 0, 0, "load_0100");
    cmd(1, 0, 0, 0, 6'd1, 6'd0);
    S = cyc + 1;
    exp_tick(S + 10, 0, 59, 0, "t_borrow");
    exp_at(S + 12, 0, 0, 0, 0, 0, 0, "clear_run");
    cmd(0, 1, 0, 0, 6'd0, 6'd0);
    wait_until(S + 11);
    cmd(0, 0, 0, 1, 6'd0, 6'd0);

    // Pause 4 clocks after start, resume; partial second preserved
    S = cyc + 1;
    exp_at(S, 0, 5, 0, 0, 0, 0, "load_0005");
    cmd(1, 0, 0, 0, 6'd0, 6'd5);
    S = cyc + 1;
    exp_at(S + 4, 0, 5, 0, 1, 0, 0, "paused");
    exp_at(S + 54, 0, 5, 0, 1, 0, 0, "pause_hold");
    exp_at(S + 55, 0, 5, 1, 0, 0, 0, "resume");
    exp_tick(S + 61, 0, 4, 0, "t_after_resume");
    cmd(0, 1, 0, 0, 6'd0, 6'd0);
    wait_until(S + 3);
    cmd(0, 0, 1, 0, 6'd0, 6'd0);
    wait_until(S + 54);
    cmd(0, 1, 0, 0, 6'd0, 6'd0);
    wait_until(S + 62);
    cmd(0, 0, 0, 1, 6'd0, 6'd0);

    // Clamp out-of-range presets, then start at 00:00 is ignored
    S = cyc + 1;
    exp_at(S, 59, 59, 0, 0, 0, 0, "clamp_6063");
    cmd(1, 0, 0, 0, 6'd60, 6'd63);
    S = cyc + 1;
    exp_at(S, 0, 0, 0, 0, 0, 0, "clear_idle");
    cmd(0, 0, 0, 1, 6'd0, 6'd0);
    S = cyc + 1;
    exp_at(S, 0, 0, 0, 0, 0, 0, "start_zero");
    exp_at(S + 12, 0, 0, 0, 0, 0, 0, "start_zero_idle");
    cmd(0, 1, 0, 0, 6'd0, 6'd0);
    wait_until(S + 12);

    // Pause and clear together in RUN: clear wins
    S = cyc + 1;
    exp_at(S, 0, 10, 0, 0, 0, 0, "load_0010");
    cmd(1, 0, 0, 0, 6'd0, 6'd10);
    S = cyc + 1;
    exp_at(S + 2, 0, 0, 0, 0, 0, 0, "pause_clear");
    cmd(0, 1, 0, 0, 6'd0, 6'd0);
    wait_until(S + 1);
    cmd(0, 0, 1, 1, 6'd0, 6'd0);

    // Tick coinciding with pause: decrement first, then paused
    S = cyc + 1;
    exp_at(S, 0, 2, 0, 0, 0, 0, "load_0002");
    cmd(1, 0, 0, 0, 6'd0, 6'd2);
    S = cyc + 1;
    exp_tick(S + 10, 0, 1, 0, "t_with_pause");
    exp_at(S + 10, 0, 1, 0, 1, 0, 1, "tick_pause");
    exp_at(S + 30, 0, 1, 0, 1, 0, 0, "tick_pause_hold");
    cmd(0, 1, 0, 0, 6'd0, 6'd0);
    wait_until(S + 9);
    cmd(0, 0, 1, 0, 6'd0, 6'd0);
    wait_until(S + 30);
    cmd(0, 0, 0, 1, 6'd0, 6'd0);

    // Reset mid-RUN at 00:07, then a load is accepted and counting restarts
    S = cyc + 1;
    exp_at(S, 0, 8, 0, 0, 0, 0, "load_0008");
    cmd(1, 0, 0, 0, 6'd0, 6'd8);
    S = cyc + 1;
    exp_tick(S + 10, 0, 7, 0, "t_sec7");
    exp_at(S + 12, 0, 0, 0, 0, 0, 0, "reset_mid_run");
    cmd(0, 1, 0, 0, 6'd0, 6'd0);
    wait_until(S + 11);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    S = cyc + 1;
    exp_at(S, 0, 4, 0, 0, 0, 0, "load_after_reset");
    cmd(1, 0, 0, 0, 6'd0, 6'd4);
    S = cyc + 1;
    exp_at(S, 0, 4, 1, 0, 0, 0, "start_after_reset");
    exp_tick(S + 10, 0, 3, 0, "t_after_reset");
    cmd(0, 1, 0, 0, 6'd0, 6'd0);
    wait_until(S + 12);
    cmd(0, 0, 0, 1, 6'd0, 6'd0);
    repeat (3) @(negedge clk);

    checks++;
    if (at_q.size() != 0 || tk_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d state and %0d tick expectations unconsumed, want 0 and 0",
               at_q.size(), tk_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
